// File: rtl/cache_pkg.sv
// Shared cache-line geometry and the refill FSM state type.
package cache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_MSB  = 3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

endpackage

// File: rtl/line_refill_buffer.sv
// Cache-miss refill engine: fetches a 4-word line critical word first with wrap-around
// and holds the assembled words plus the critical-word select for the downstream word mux.
module line_refill_buffer
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              crit_valid,
    output logic              fill_done,
    output logic [DATA_W-1:0] w0,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic [DATA_W-1:0] w3,
    output logic [1:0]        word_sel
);

    localparam int IDX_W = INDEX_MSB - OFFSET_LSB + 1;

    state_t                                state;
    logic [ADDR_W-INDEX_MSB-2:0]           base;
    logic [IDX_W-1:0]                      cnt;
    logic [IDX_W-1:0]                      idx;
    logic [IDX_W-1:0]                      next_idx;
    logic                                  beat_ack;
    logic [LINE_WORDS-1:0]                 slot_en;
    logic [LINE_WORDS-1:0][DATA_W-1:0]     words;
    logic                                  unused_addr_bits;

    // Byte-offset bits of the miss address never reach memory.
    assign unused_addr_bits = ^miss_addr[OFFSET_LSB-1:0];

    assign idx      = word_sel + cnt;
    assign next_idx = idx + IDX_W'(1);
    assign beat_ack = (state == FETCH) && mem_ack && !flush;
    assign busy     = (state != IDLE);

    always_comb begin
        slot_en = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            slot_en[i] = beat_ack && (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= '0;
            cnt        <= '0;
            word_sel   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            crit_valid <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            crit_valid <= 1'b0;
            fill_done  <= 1'b0;
            // A flush wins over any ack or new miss arriving in the same cycle.
            if (flush) begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (miss_req) begin
                            base     <= miss_addr[ADDR_W-1:INDEX_MSB+1];
                            word_sel <= miss_addr[INDEX_MSB:OFFSET_LSB];
                            cnt      <= '0;
                            mem_req  <= 1'b1;
                            mem_addr <= {miss_addr[ADDR_W-1:OFFSET_LSB], {OFFSET_LSB{1'b0}}};
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (mem_ack) begin
                            cnt      <= cnt + IDX_W'(1);
                            mem_addr <= {base, next_idx, {OFFSET_LSB{1'b0}}};
                            if (cnt == '0) begin
                                crit_valid <= 1'b1;
                            end
                            if (cnt == IDX_W'(LINE_WORDS - 1)) begin
                                mem_req   <= 1'b0;
                                fill_done <= 1'b1;
                                state     <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words <= '0;
        end else begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (slot_en[i]) begin
                    words[i] <= mem_rdata;
                end
            end
        end
    end

    assign w0 = words[0];
    assign w1 = words[1];
    assign w2 = words[2];
    assign w3 = words[3];

endmodule
